// File: rtl/mercury2_adc_reader.sv
// Mercury2 MCP3008 reader: SPI mode (0,0) master that fetches one 10-bit conversion per trigger.
// Busy spans the whole frame plus the CS-high gap, so a new trigger always respects tCSH.
module mercury2_adc_reader #(
    parameter int unsigned SckHalf      = 25,
    parameter int unsigned CsHighClocks = 14
) (
    input  logic       clk_50MHZ,
    input  logic       reset,
    input  logic       trigger,
    input  logic [2:0] channel,
    input  logic       single,
    output logic [9:0] Dout,
    output logic       DataReady,
    output logic       Busy,
    output logic       adc_csn,
    output logic       adc_sck,
    output logic       adc_mosi,
    input  logic       adc_miso
);

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        TAIL,
        GAP
    } state_t;

    localparam logic [7:0] HALF_RELOAD = 8'(SckHalf - 1);
    localparam logic [7:0] GAP_RELOAD  = 8'(CsHighClocks - 1);
    localparam logic [4:0] FIRST_DATA  = 5'd8;
    localparam logic [4:0] LAST_BIT    = 5'd17;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [4:0] k_q, k_d;
    logic [9:0] shift_q, shift_d;
    logic [9:0] dout_q, dout_d;
    logic [2:0] chan_q, chan_d;
    logic       single_q, single_d;
    logic       csn_q, csn_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic [1:0] miso_sync_q;

    // Command bits: start, SGL/DIFF, D2..D0; everything after is don't-care to the ADC.
    function automatic logic mosi_for(input logic [4:0] k, input logic sgl, input logic [2:0] ch);
        case (k)
            5'd1:    mosi_for = 1'b1;
            5'd2:    mosi_for = sgl;
            5'd3:    mosi_for = ch[2];
            5'd4:    mosi_for = ch[1];
            5'd5:    mosi_for = ch[0];
            default: mosi_for = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk_50MHZ or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            k_q         <= '0;
            shift_q     <= '0;
            dout_q      <= '0;
            chan_q      <= '0;
            single_q    <= 1'b0;
            csn_q       <= 1'b1;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            miso_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            chan_q      <= chan_d;
            single_q    <= single_d;
            csn_q       <= csn_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            miso_sync_q <= {miso_sync_q[0], adc_miso};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        shift_d  = shift_q;
        dout_d   = dout_q;
        chan_d   = chan_q;
        single_d = single_q;
        csn_d    = csn_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        ready_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    chan_d   = channel;
                    single_d = single;
                    csn_d    = 1'b0;
                    sck_d    = 1'b0;
                    mosi_d   = 1'b1;
                    k_d      = 5'd1;
                    cnt_d    = HALF_RELOAD;
                    state_d  = LOW;
                end
            end
            LOW: begin
                if (cnt_q == 8'd0) begin
                    sck_d = 1'b1;
                    // Bits 6 (sample) and 7 (null) carry no data.
                    if (k_q >= FIRST_DATA && k_q <= LAST_BIT) begin
                        shift_d = {shift_q[8:0], miso_sync_q[1]};
                    end
                    cnt_d   = HALF_RELOAD;
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HIGH: begin
                if (cnt_q == 8'd0) begin
                    sck_d = 1'b0;
                    cnt_d = HALF_RELOAD;
                    if (k_q < LAST_BIT) begin
                        k_d     = k_q + 5'd1;
                        mosi_d  = mosi_for(k_q + 5'd1, single_q, chan_q);
                        state_d = LOW;
                    end else begin
                        state_d = TAIL;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            TAIL: begin
                if (cnt_q == 8'd0) begin
                    csn_d   = 1'b1;
                    mosi_d  = 1'b0;
                    dout_d  = shift_q;
                    ready_d = 1'b1;
                    cnt_d   = GAP_RELOAD;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign Dout      = dout_q;
    assign DataReady = ready_q;
    assign Busy      = busy_q;
    assign adc_csn   = csn_q;
    assign adc_sck   = sck_q;
    assign adc_mosi  = mosi_q;

endmodule

// File: tb/tb_mercury2_adc_reader.sv
// Directed bench for mercury2_adc_reader: two instances (default timing and SckHalf=2)
// each talking to a small behavioural MCP3008 model.
module tb_mercury2_adc_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       trigger, single, adc_miso;
    logic [2:0] channel;
    logic [9:0] Dout;
    logic       DataReady, Busy, adc_csn, adc_sck, adc_mosi;

    logic       trig2, sgl2, miso2;
    logic [2:0] ch2;
    logic [9:0] Dout2;
    logic       dr2, busy2, csn2, sck2, mosi2;

    logic [9:0] adc_val, adc_val2;
    logic [4:0] mosi_bits, mosi_bits2;
    int         rise_cnt, rise_cnt2;
    int         tests_run, tests_failed;

    always #10 clk = ~clk;

    mercury2_adc_reader dut (
        .clk_50MHZ(clk), .reset(reset), .trigger(trigger), .channel(channel),
        .single(single), .Dout(Dout), .DataReady(DataReady), .Busy(Busy),
        .adc_csn(adc_csn), .adc_sck(adc_sck), .adc_mosi(adc_mosi), .adc_miso(adc_miso)
    );

    mercury2_adc_reader #(.SckHalf(2), .CsHighClocks(3)) dut2 (
        .clk_50MHZ(clk), .reset(reset), .trigger(trig2), .channel(ch2),
        .single(sgl2), .Dout(Dout2), .DataReady(dr2), .Busy(busy2),
        .adc_csn(csn2), .adc_sck(sck2), .adc_mosi(mosi2), .adc_miso(miso2)
    );

    // ADC model: latches DIN on SCK rise, presents the next bit shortly after each rise.
    always @(posedge adc_sck or posedge reset or negedge adc_csn) begin
        if (reset) begin
            rise_cnt = 0;
            adc_miso = 1'b0;
        end else if (!adc_sck) begin
            rise_cnt  = 0;
            mosi_bits = '0;
        end else begin
            rise_cnt++;
            if (rise_cnt <= 5) mosi_bits = {mosi_bits[3:0], adc_mosi};
            #1;
            if (rise_cnt >= 7 && rise_cnt <= 16) adc_miso = adc_val[4'(16 - rise_cnt)];
            else adc_miso = 1'b0;
        end
    end

    always @(posedge sck2 or posedge reset or negedge csn2) begin
        if (reset) begin
            rise_cnt2 = 0;
            miso2     = 1'b0;
        end else if (!sck2) begin
            rise_cnt2  = 0;
            mosi_bits2 = '0;
        end else begin
            rise_cnt2++;
            if (rise_cnt2 <= 5) mosi_bits2 = {mosi_bits2[3:0], mosi2};
            #1;
            if (rise_cnt2 >= 7 && rise_cnt2 <= 16) miso2 = adc_val2[4'(16 - rise_cnt2)];
            else miso2 = 1'b0;
        end
    end

    task automatic test_reset();
        int sck_edges;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (adc_csn !== 1'b1) begin tests_failed++; $display("FAIL reset_csn got %b want 1", adc_csn); end
        tests_run++; if (adc_sck !== 1'b0) begin tests_failed++; $display("FAIL reset_sck got %b want 0", adc_sck); end
        tests_run++; if (adc_mosi !== 1'b0) begin tests_failed++; $display("FAIL reset_mosi got %b want 0", adc_mosi); end
        tests_run++; if (Busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", Busy); end
        tests_run++; if (DataReady !== 1'b0) begin tests_failed++; $display("FAIL reset_dataready got %b want 0", DataReady); end
        tests_run++; if (Dout !== 10'h000) begin tests_failed++; $display("FAIL reset_dout got %h want 000", Dout); end
        @(negedge clk);
        reset = 1'b0;
        sck_edges = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (adc_sck || !adc_csn || Busy || sck2) sck_edges++;
        end
        tests_run++; if (sck_edges !== 0) begin tests_failed++; $display("FAIL idle_no_activity got %0d active cycles want 0", sck_edges); end
    endtask

    task automatic test_single_read();
        int n, dr_n, busy_n, dr_cnt, csn_low_in_gap;
        logic [9:0] dout_at_dr;
        adc_val = 10'h2A5;
        @(negedge clk);
        channel = 3'd5; single = 1'b1; trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        n = 1; dr_n = -1; busy_n = -1; dr_cnt = 0; csn_low_in_gap = 0; dout_at_dr = 'x;
        tests_run++; if (Busy !== 1'b1 || adc_csn !== 1'b0) begin tests_failed++; $display("FAIL accept_busy_csn got %b%b want 10", Busy, adc_csn); end
        while (busy_n < 0 && n < 2000) begin
            @(posedge clk); n++; #1;
            if (DataReady) begin dr_cnt++; dr_n = n; dout_at_dr = Dout; end
            if (dr_n > 0 && !adc_csn) csn_low_in_gap++;
            if (!Busy) busy_n = n;
        end
        tests_run++; if (rise_cnt !== 17) begin tests_failed++; $display("FAIL sck_pulses got %0d want 17", rise_cnt); end
        tests_run++; if (mosi_bits !== 5'b11101) begin tests_failed++; $display("FAIL mosi_cmd got %b want 11101", mosi_bits); end
        tests_run++; if (dr_n !== 876) begin tests_failed++; $display("FAIL dataready_clock got %0d want 876", dr_n); end
        tests_run++; if (dr_cnt !== 1) begin tests_failed++; $display("FAIL dataready_count got %0d want 1", dr_cnt); end
        tests_run++; if (dout_at_dr !== 10'h2A5) begin tests_failed++; $display("FAIL dout_2a5 got %h want 2a5", dout_at_dr); end
        tests_run++; if (busy_n !== 890) begin tests_failed++; $display("FAIL busy_fall_clock got %0d want 890", busy_n); end
        tests_run++; if (csn_low_in_gap !== 0 || adc_csn !== 1'b1) begin tests_failed++; $display("FAIL csn_gap got %0d low cycles want 0", csn_low_in_gap); end
        repeat (20) @(posedge clk);
        #1;
        tests_run++; if (Dout !== 10'h2A5) begin tests_failed++; $display("FAIL dout_hold got %h want 2a5", Dout); end
    endtask

    task automatic test_back_to_back();
        int n, dr_total, busy_n;
        logic [9:0] dout1, dout2;
        logic [4:0] mosi1;
        logic accepted;
        adc_val = 10'h3FF;
        @(negedge clk);
        channel = 3'd3; single = 1'b1; trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        n = 1; dr_total = 0; busy_n = -1; dout1 = 'x; dout2 = 'x;
        while (busy_n < 0 && n < 2000) begin
            @(posedge clk); n++; #1;
            if (n == 30) begin channel = 3'd0; single = 1'b0; trigger = 1'b1; end
            if (n == 31) trigger = 1'b0;
            if (DataReady) begin dr_total++; dout1 = Dout; adc_val = 10'h000; end
            if (!Busy) busy_n = n;
        end
        mosi1 = mosi_bits;
        channel = 3'd6; single = 1'b0; trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        accepted = Busy && !adc_csn;
        n = 1; busy_n = -1;
        while (busy_n < 0 && n < 2000) begin
            @(posedge clk); n++; #1;
            if (DataReady) begin dr_total++; dout2 = Dout; end
            if (!Busy) busy_n = n;
        end
        tests_run++; if (dout1 !== 10'h3FF) begin tests_failed++; $display("FAIL b2b_dout1 got %h want 3ff", dout1); end
        tests_run++; if (mosi1 !== 5'b11011) begin tests_failed++; $display("FAIL b2b_mosi1 got %b want 11011", mosi1); end
        tests_run++; if (accepted !== 1'b1) begin tests_failed++; $display("FAIL b2b_first_idle_accept got %b want 1", accepted); end
        tests_run++; if (dout2 !== 10'h000) begin tests_failed++; $display("FAIL b2b_dout2 got %h want 000", dout2); end
        tests_run++; if (mosi_bits !== 5'b10110) begin tests_failed++; $display("FAIL b2b_mosi2 got %b want 10110", mosi_bits); end
        tests_run++; if (dr_total !== 2) begin tests_failed++; $display("FAIL b2b_dataready_count got %0d want 2", dr_total); end
    endtask

    task automatic test_differential();
        int n, dr_n, busy_n, runs, bad_runs, run;
        logic prev;
        logic [9:0] dout_at_dr;
        adc_val2 = 10'h155;
        @(negedge clk);
        ch2 = 3'd2; sgl2 = 1'b0; trig2 = 1'b1;
        @(posedge clk); #1;
        trig2 = 1'b0;
        n = 1; dr_n = -1; busy_n = -1; runs = 0; bad_runs = 0; run = 1; prev = sck2; dout_at_dr = 'x;
        while (busy_n < 0 && n < 500) begin
            @(posedge clk); n++; #1;
            if (sck2 !== prev) begin
                runs++;
                if (run != 2) bad_runs++;
                run = 1;
                prev = sck2;
            end else begin
                run++;
            end
            if (dr2) begin dr_n = n; dout_at_dr = Dout2; end
            if (!busy2) busy_n = n;
        end
        tests_run++; if (mosi_bits2 !== 5'b10010) begin tests_failed++; $display("FAIL diff_mosi got %b want 10010", mosi_bits2); end
        tests_run++; if (rise_cnt2 !== 17) begin tests_failed++; $display("FAIL diff_sck_pulses got %0d want 17", rise_cnt2); end
        tests_run++; if (runs !== 34 || bad_runs !== 0) begin tests_failed++; $display("FAIL diff_sck_halves got %0d runs %0d bad want 34 runs 0 bad", runs, bad_runs); end
        tests_run++; if (dr_n !== 71) begin tests_failed++; $display("FAIL diff_dataready_clock got %0d want 71", dr_n); end
        tests_run++; if (dout_at_dr !== 10'h155) begin tests_failed++; $display("FAIL diff_dout got %h want 155", dout_at_dr); end
        tests_run++; if (busy_n !== 74) begin tests_failed++; $display("FAIL diff_busy_fall got %0d want 74", busy_n); end
    endtask

    task automatic test_reset_mid_frame();
        int n, dr_seen, sck_seen, dr_n;
        logic [9:0] dout_at_dr;
        adc_val = 10'h1C3;
        @(negedge clk);
        channel = 3'd5; single = 1'b1; trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        n = 0;
        while (rise_cnt < 10 && n < 2000) begin
            @(posedge clk); n++; #1;
        end
        tests_run++; if (rise_cnt !== 10) begin tests_failed++; $display("FAIL midrst_reach_pulse10 got %0d want 10", rise_cnt); end
        reset = 1'b1;
        #1;
        tests_run++; if (adc_csn !== 1'b1 || adc_sck !== 1'b0) begin tests_failed++; $display("FAIL midrst_csn_sck got %b%b want 10", adc_csn, adc_sck); end
        tests_run++; if (Dout !== 10'h000 || DataReady !== 1'b0 || Busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_outputs got dout=%h dr=%b busy=%b want 000 0 0", Dout, DataReady, Busy); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        dr_seen = 0; sck_seen = 0;
        repeat (1000) begin
            @(posedge clk); #1;
            if (DataReady) dr_seen++;
            if (adc_sck || !adc_csn) sck_seen++;
        end
        tests_run++; if (dr_seen !== 0 || sck_seen !== 0 || Dout !== 10'h000) begin tests_failed++; $display("FAIL midrst_quiet got dr=%0d active=%0d dout=%h want 0 0 000", dr_seen, sck_seen, Dout); end
        adc_val = 10'h0F0;
        @(negedge clk);
        channel = 3'd1; single = 1'b1; trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        n = 1; dr_n = -1; dout_at_dr = 'x;
        while (dr_n < 0 && n < 2000) begin
            @(posedge clk); n++; #1;
            if (DataReady) begin dr_n = n; dout_at_dr = Dout; end
        end
        tests_run++; if (dr_n !== 876 || dout_at_dr !== 10'h0F0) begin tests_failed++; $display("FAIL midrst_next_frame got clk=%0d dout=%h want 876 0f0", dr_n, dout_at_dr); end
        tests_run++; if (mosi_bits !== 5'b11001) begin tests_failed++; $display("FAIL midrst_next_mosi got %b want 11001", mosi_bits); end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        trigger = 1'b0; channel = '0; single = 1'b0;
        trig2 = 1'b0; ch2 = '0; sgl2 = 1'b0;
        adc_val = '0; adc_val2 = '0;
        mosi_bits = '0; mosi_bits2 = '0;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_differential();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
